// File: rtl/local_weight_buffer.sv
// Weight store: streaming burst loader writes a register file, reads return G consecutive weights as packed lanes.
// Latency: read data registered one cycle after the request; a write is readable the cycle after its beat or via same-cycle bypass.
// Backpressure: wr_ready is high only while a burst is loading; reads never stall and accept one request per cycle.
module local_weight_buffer #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 2048,
   parameter int LANES  = 8,
   parameter int ADDR_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ld_start,
   input  logic [ADDR_W-1:0]       ld_base,
   input  logic [ADDR_W-1:0]       ld_len,
   input  logic                    wr_valid,
   input  logic [DATA_W-1:0]       wr_data,
   output logic                    wr_ready,
   output logic                    ld_busy,
   output logic                    ld_done,
   output logic                    ld_err,
   input  logic                    rd_req,
   input  logic [ADDR_W-1:0]       rd_addr,
   input  logic [3:0]              rd_group,
   output logic                    rd_valid,
   output logic [LANES*DATA_W-1:0] rd_data,
   output logic                    rd_oob
);

   localparam int MA_W  = $clog2(DEPTH);
   // Pointer has one spare bit so base + length never wraps back into range.
   localparam int PTR_W = ADDR_W + 1;
   // Read addresses are rd_addr * G + j, kept at full width so large groups cannot alias low entries.
   localparam int EA_W  = ADDR_W + 4;
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
   localparam logic [EA_W-1:0]  DEPTH_E = EA_W'(DEPTH);

   typedef enum logic {IDLE, LOAD} state_t;

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [ADDR_W-1:0]  remaining;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic               beat;
   logic               beat_in_range;

   logic [3:0]              grp;
   logic [EA_W-1:0]         base;
   logic [EA_W-1:0]         lane_addr;
   logic [LANES*DATA_W-1:0] data_n;
   logic                    oob_n;

   assign beat          = wr_valid && wr_ready;
   assign beat_in_range = beat && (ptr < DEPTH_P);

   // Load sequencer: captures a burst in IDLE, counts accepted beats in LOAD, flags writes past the end.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
         wr_ready  <= 1'b0;
         ld_busy   <= 1'b0;
         ld_done   <= 1'b0;
         ld_err    <= 1'b0;
      end else begin
         ld_done <= 1'b0;
         case (state)
            IDLE: begin
               if (ld_start) begin
                  ld_err <= 1'b0;
                  if (ld_len == '0) begin
                     ld_done <= 1'b1;
                  end else begin
                     ptr       <= {1'b0, ld_base};
                     remaining <= ld_len;
                     state     <= LOAD;
                     wr_ready  <= 1'b1;
                     ld_busy   <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (beat) begin
                  if (!(ptr < DEPTH_P)) begin
                     ld_err <= 1'b1;
                  end
                  ptr       <= ptr + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == ADDR_W'(1)) begin
                     state    <= IDLE;
                     wr_ready <= 1'b0;
                     ld_busy  <= 1'b0;
                     ld_done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Register-file storage: cleared only by reset, written by in-range load beats.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (beat_in_range) begin
         mem[ptr[MA_W-1:0]] <= wr_data;
      end
   end

   // Read lane assembly: clamp the group size, range-check each lane, and forward a same-cycle write.
   always_comb begin
      grp       = (rd_group > 4'(LANES)) ? 4'(LANES) : rd_group;
      base      = EA_W'(rd_addr) * EA_W'(grp);
      data_n    = '0;
      oob_n     = 1'b0;
      lane_addr = '0;
      for (int j = 0; j < LANES; j++) begin
         lane_addr = base + EA_W'(j);
         if (j < int'(grp)) begin
            if (lane_addr >= DEPTH_E) begin
               oob_n = 1'b1;
            end else if (beat_in_range && (EA_W'(ptr) == lane_addr)) begin
               data_n[j*DATA_W +: DATA_W] = wr_data;
            end else begin
               data_n[j*DATA_W +: DATA_W] = mem[lane_addr[MA_W-1:0]];
            end
         end
      end
   end

   // Registered read port: outputs are all zero in any cycle that follows no request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_oob   <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_req;
         rd_oob   <= rd_req && oob_n;
         rd_data  <= rd_req ? data_n : '0;
      end
   end

endmodule

// File: doc/local_weight_buffer.md
# local_weight_buffer

Parametrised weight store for the convolution datapath: a register-file memory filled by a streaming load sequencer and read as a packed multi-lane word, one group of consecutive weights per request. Replaces the fixed 3-lane/8-lane local weight memory with runtime-selectable group size, a registered read port, write-to-read bypass and out-of-range detection. Sits between the DMA/weight loader and the PE-array weight registers.

## Interface
- DATA_W, 16, bits per weight
- DEPTH, 2048, number of weight entries
- LANES, 8, maximum weights per read word
- ADDR_W, 16, width of all address/length ports
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- ld_start  in  1  start a load burst (accepted only in IDLE)
- ld_base  in  ADDR_W  first entry written by the burst
- ld_len  in  ADDR_W  number of weights in the burst
- wr_valid  in  1  stream data valid
- wr_data  in  DATA_W  stream weight
- wr_ready  out  1  buffer accepts stream data
- ld_busy  out  1  sequencer in LOAD
- ld_done  out  1  one-cycle pulse at burst completion
- ld_err  out  1  sticky: a burst write fell at or beyond DEPTH
- rd_req  in  1  read request
- rd_addr  in  ADDR_W  group index
- rd_group  in  4  weights per group (group size G)
- rd_valid  out  1  rd_data valid
- rd_data  out  LANES*DATA_W  lane j in bits [j*DATA_W +: DATA_W]
- rd_oob  out  1  at least one requested lane was out of range

## Operation
- Storage: DEPTH x DATA_W registers, all cleared to 0 on reset; no other clear path.
- Sequencer states IDLE, LOAD.
  - IDLE: wr_ready=0. ld_start with ld_len>0 -> capture ptr=ld_base, remaining=ld_len, clear ld_err, go LOAD. ld_start with ld_len=0 -> stay IDLE, ld_done pulses next cycle, ld_err cleared, no write.
  - LOAD: wr_ready=1, ld_busy=1. Beat = wr_valid&&wr_ready: if ptr<DEPTH write mem[ptr]=wr_data, else drop the beat and set ld_err. ptr++, remaining--. The beat that takes remaining to 0 -> IDLE next cycle with ld_done=1 for that cycle. ld_start is ignored in LOAD.
- Read: on rd_req, G = min(rd_group, LANES); base = rd_addr*G computed at full width (ADDR_W+4 bits, no truncation). Lane j<G: address base+j; if that address is >=DEPTH the lane is 0 and rd_oob=1, else mem[base+j]. Lanes j>=G: 0. G=0 returns all-zero data, rd_valid=1, rd_oob=0.
- Bypass: if a load beat writes address A in the same cycle a request reads A, that lane returns the new wr_data, not the old contents.
- Reads are allowed in both states and do not stall the sequencer.
- Reset while in LOAD: immediate return to IDLE; memory contents are zeroed and the partial burst is lost.

## Timing
- Reset values: wr_ready=0, ld_busy=0, ld_done=0, ld_err=0, rd_valid=0, rd_oob=0, rd_data=0.
- Read latency 1: request sampled at edge N -> rd_data/rd_valid/rd_oob registered at edge N and valid during cycle N+1. A back-to-back request every cycle gives full throughput.
- No request in cycle N -> in cycle N+1, rd_valid=0, rd_oob=0 and rd_data=0.
- Write is visible to a non-bypassed read issued in the cycle after the beat.
- ld_start at edge N -> wr_ready=1 from cycle N+1. The last beat at edge M -> wr_ready=0 and ld_done=1 in cycle M+1.
- Burst of L beats with wr_valid held high occupies exactly L cycles of LOAD.

## Test plan
- Reset mid-burst: assert rst=0 after 3 beats -> all outputs 0, wr_ready=0; a read of addr 0 with G=8 returns 0.
- Burst load: ld_base=0, ld_len=24, values 1..24 with gaps in wr_valid -> ld_done pulses once after beat 24. Read rd_addr=1, G=8 -> lanes 9..16. Read rd_addr=2, G=3 -> lanes 7,8,9, upper lanes 0.
- Bypass: during a load writing 0xBEEF to entry 40, read rd_addr=5, G=8 in the same cycle -> lane 0=0xBEEF.
- Range: ld_base=DEPTH-2, ld_len=4 -> two writes land and ld_err=1. Read rd_addr=(DEPTH-4)/4, G=4... then rd_addr=DEPTH/8, G=8 -> all lanes 0 and rd_oob=1. A read ending exactly at DEPTH-1 -> rd_oob=0.
- Edge cases: ld_len=0 -> ld_done=1 next cycle with no memory change. rd_group=12 behaves as G=8. rd_group=0 -> rd_valid=1 with zero data. ld_start during LOAD is ignored, and the count is unaffected.
